// File: rtl/ms_ff_bank.sv
// ms_ff_bank: a bank of WIDTH master/slave flip-flops with a selectable
// function (SR, JK, D or T), applied to every bit in parallel.
//
// The master register m updates from its own current value when en=1, using
// the function selected by mode. The slave register q loads the pre-edge
// value of m on every edge, so q lags m by exactly one cycle.
//
// An illegal SR cycle is one where en=1, mode=SR and at least one bit has
// S=R=1. Such bits hold, while the other bits still update normally. Each
// illegal cycle sets the sticky flag err and bumps the saturating counter
// err_cnt by one.
//
// Ports:
//   clk      in   1      clock; all state changes on the rising edge
//   rst      in   1      synchronous active-high reset (highest priority)
//   en       in   1      master update enable
//   mode     in   2      00=SR, 01=JK, 10=D, 11=T
//   a        in   WIDTH  per-bit S / J / D / T
//   b        in   WIDTH  per-bit R / K (ignored in D and T modes)
//   q        out  WIDTH  slave register
//   qn       out  WIDTH  ~q
//   err      out  1      sticky illegal-SR flag
//   err_cnt  out  CNT_W  saturating count of illegal-SR cycles
module ms_ff_bank #(
  parameter int unsigned             WIDTH = 4,
  parameter logic [WIDTH-1:0]        INIT  = '0,
  parameter int unsigned             CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    m_d     = m_q;
    illegal = 1'b0;
    if (en) begin
      unique case (mode_sel)
        // Set where S&~R, clear where R&~S; S=R=1 bits fall through to hold.
        MODE_SR: begin
          m_d     = (m_q & ~(b & ~a)) | (a & ~b);
          illegal = |(a & b);
        end
        // J sets a 0, ~K keeps a 1: covers hold/set/clear/toggle in one term.
        MODE_JK: m_d = (a & ~m_q) | (~b & m_q);
        MODE_D:  m_d = a;
        MODE_T:  m_d = m_q ^ a;
      endcase
    end
  end

  always_comb begin
    err_d = err_q | illegal;
    cnt_d = cnt_q;
    if (illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= INIT;
      q_q   <= INIT;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      q_q   <= m_q;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_q;
  assign qn      = ~q_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_ms_ff_bank.sv
// Directed test for ms_ff_bank (WIDTH=4, INIT=0, CNT_W=2). The stimulus
// process drives one vector per cycle and queues the hand-computed state
// expected after the following rising edge; a separate monitor pops and
// compares each entry just after that edge.
module tb_ms_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] q;
  logic [3:0] qn;
  logic       err;
  logic [1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         step;
    logic [3:0] q;
    logic       err;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];

  ms_ff_bank #(
    .WIDTH (4),
    .INIT  (4'b0000),
    .CNT_W (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .q       (q),
    .qn      (qn),
    .err     (err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q) begin
          failures++;
          $display("FAIL step%0d q: got %b expected %b", e.step, q, e.q);
        end
        checks++;
        if (qn !== ~e.q) begin
          failures++;
          $display("FAIL step%0d qn: got %b expected %b", e.step, qn, ~e.q);
        end
        checks++;
        if (err !== e.err) begin
          failures++;
          $display("FAIL step%0d err: got %b expected %b", e.step, err, e.err);
        end
        checks++;
        if (err_cnt !== e.cnt) begin
          failures++;
          $display("FAIL step%0d err_cnt: got %0d expected %0d", e.step, err_cnt, e.cnt);
        end
      end
    end
  end

  int step_no = 0;

  // Drive one vector on the falling edge and queue the state expected after
  // the next rising edge.
  task automatic vec(input logic r, input logic e_n, input logic [1:0] md,
                     input logic [3:0] va, input logic [3:0] vb,
                     input logic [3:0] eq, input logic eerr, input logic [1:0] ecnt);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e_n;
    mode = md;
    a    = va;
    b    = vb;
    step_no++;
    x.step = step_no;
    x.q    = eq;
    x.err  = eerr;
    x.cnt  = ecnt;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0;

    //   rst  en  mode   a        b        exp q    err  cnt
    // reset
    vec(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    // SR set then clear, two-edge latency
    vec(1'b0, 1'b1, 2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0101, 4'b0000, 4'b0101, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0101, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0100, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    // load m=0101 with D, then JK toggle for three edges
    vec(1'b0, 1'b1, 2'b10, 4'b0101, 4'b0000, 4'b0100, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0101, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 4'b1010, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0101, 1'b0, 2'd0);
    // reset, then illegal SR for five edges with counter saturation at 3
    vec(1'b1, 1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0010, 4'b0000, 1'b1, 2'd1);
    vec(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0010, 4'b0001, 1'b1, 2'd2);
    vec(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0010, 4'b0001, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0010, 4'b0001, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0010, 4'b0001, 1'b1, 2'd3);
    // enable gating, then D and T
    vec(1'b0, 1'b0, 2'b10, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd3);
    vec(1'b0, 1'b0, 2'b10, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b10, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b11, 4'b1000, 4'b0000, 4'b1111, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0111, 1'b1, 2'd3);
    // bring m=q=1111, then reset during an illegal SR cycle
    vec(1'b0, 1'b1, 2'b10, 4'b1111, 4'b0000, 4'b0111, 1'b1, 2'd3);
    vec(1'b0, 1'b1, 2'b10, 4'b1111, 4'b0000, 4'b1111, 1'b1, 2'd3);
    vec(1'b1, 1'b1, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0);
    // a=b=1 not flagged with en=0, nor in JK / D / T
    vec(1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b10, 4'b1010, 4'b1010, 4'b1111, 1'b0, 2'd0);
    vec(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0011, 4'b1010, 1'b0, 2'd0);
    // mixed SR cycle: bit3 clear, bit2 illegal hold, bit1 set, bit0 hold
    vec(1'b0, 1'b1, 2'b00, 4'b0110, 4'b1100, 4'b1001, 1'b1, 2'd1);
    vec(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0011, 1'b1, 2'd1);

    // drain the scoreboard, bounded
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ms_ff_bank.md
MS_FF_BANK -- requirements
Module: ms_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of flip-flop bits.
REQ-002 SHALL have parameter INIT, default 0, WIDTH-bit reset value of the master and slave registers.
REQ-003 SHALL have parameter CNT_W, default 4, width of the illegal-event counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  master update enable.
REQ-007 SHALL have port mode  input  2  function select: 00=SR, 01=JK, 10=D, 11=T.
REQ-008 SHALL have port a  input  WIDTH  per-bit S / J / D / T input, by mode.
REQ-009 SHALL have port b  input  WIDTH  per-bit R / K input; ignored in D and T modes.
REQ-010 SHALL have port q  output  WIDTH  slave register.
REQ-011 SHALL have port qn  output  WIDTH  bitwise complement of q, always.
REQ-012 SHALL have port err  output  1  sticky illegal-SR flag.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating count of illegal-SR cycles.

Function
REQ-014 SHALL hold a WIDTH-bit master register m and a WIDTH-bit slave register q; m is internal.
REQ-015 SHALL, on each rising edge with en=1, update every bit of m from its own current value: SR: s=1,r=0 -> 1; s=0,r=1 -> 0; s=0,r=0 -> hold; s=1,r=1 -> hold (illegal).
REQ-016 SHALL apply JK: 00 hold, 10 set, 01 clear, 11 toggle; D: m<=a; T: bit toggles where a=1, holds where a=0.
REQ-017 SHALL hold m unchanged when en=0, regardless of mode, a and b.
REQ-018 SHALL load q<=m (pre-edge value of m) on every rising edge, independent of en; q therefore lags m by exactly one cycle.
REQ-019 SHALL make an input change visible on q two rising edges after it is sampled (sampled at edge N into m, on q after edge N+1).
REQ-020 SHALL apply a mode change on the same edge it is sampled; no pipeline of mode.
REQ-021 SHALL define an illegal cycle as en=1, mode=00 and (a & b) nonzero on a rising edge.
REQ-022 SHALL set err to 1 on the edge of an illegal cycle; err stays 1 until reset.
REQ-023 SHALL increment err_cnt by 1 per illegal cycle regardless of how many bits are illegal, saturating at 2^CNT_W-1 with no wrap.
REQ-024 SHALL not flag a==b==1 bits in JK, D or T modes, nor in SR mode with en=0.
REQ-025 SHALL update legal bits normally in an illegal cycle; only the illegal bits hold.

Reset
REQ-026 SHALL, on a rising edge with rst=1, set m=INIT, q=INIT, err=0, err_cnt=0; qn=~INIT.
REQ-027 SHALL give rst priority over en, mode and all data inputs, including mid-operation and on an illegal cycle (no error recorded).
REQ-028 SHALL resume normal updates on the first edge with rst=0; q shows m one edge later as usual.

Verification (WIDTH=4, INIT=0, CNT_W=2)
REQ-029 SHALL check reset: rst=1 for one edge -> q=4'b0000, qn=4'b1111, err=0, err_cnt=0.
REQ-030 SHALL check SR set/clear latency: mode=00, en=1, a=4'b0101, b=0 at edge 1 -> q=4'b0101 after edge 2; then a=0, b=4'b0001 -> q=4'b0100 two edges later; a=b=0 -> q stays 4'b0100.
REQ-031 SHALL check JK toggle: q=4'b0101, mode=01, a=b=4'b1111 for three edges -> q sequence 4'b0101, 4'b1010, 4'b0101 (one-cycle lag visible).
REQ-032 SHALL check illegal SR and saturation: from q=4'b0000, mode=00, a=4'b0011, b=4'b0010 for 5 edges -> q=4'b0001, err=1 after the first, err_cnt 1,2,3,3,3.
REQ-033 SHALL check enable and D/T: en=0 with mode=10, a=4'b1111 -> q unchanged; en=1 -> q=4'b1111 two edges later; mode=11, a=4'b1000 -> q=4'b0111 two edges after.
REQ-034 SHALL check reset mid-operation: m=q=4'b1111, err=1, assert rst with mode=00, a=b=4'b1111 -> q=4'b0000, err=0, err_cnt=0 after that edge.
